// File: rtl/pixel_stream_packer_pkg.sv
// Shared definitions for the RGB888 row packer: FSM encoding, lane sizing,
// FIFO word layout and row-geometry helpers.
package pixel_stream_packer_pkg;

  // Frame-level control states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Accumulator holds 0..3 pending bytes
  localparam int LANE_W = 2;

  // FIFO entry: {last, data[31:0]}
  localparam int FIFO_W = 33;

  // Bytes carried by one row of RGB888 pixels
  function automatic int bytes_per_row(input int width);
    return 3 * width;
  endfunction

  // 32-bit words per row after padding to a 4-byte boundary
  function automatic int words_per_row(input int width);
    return (3 * width + 3) / 4;
  endfunction

endpackage

// File: rtl/pixel_stream_packer_sync_fifo_fwft.sv
// First-word-fall-through FIFO. The head entry is presented combinationally
// from storage whenever the FIFO is non-empty; rdata_o reads as zero when empty
// so the packer outputs are clean after reset. A push while full is accepted
// only if the same cycle pops, since the pop frees the slot being written.
module sync_fifo_fwft #(
  parameter int DEPTH = 16,
  parameter int W     = 33
) (
  input  logic         HCLK,
  input  logic         HRESETn,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  // DEPTH is expected to be a power of two so the pointers wrap naturally
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == {(AW+1){1'b0}});
  assign pop_ok_s  = pop_i && !empty_o;
  assign push_ok_s = push_i && (!full_o || pop_ok_s);

  // Pointer and occupancy bookkeeping
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_ok_s) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage write; contents need no reset because empty gates the read side
  always_ff @(posedge HCLK) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Head-of-queue presentation, forced to zero when nothing is buffered
  always_comb begin
    rdata_o = {W{1'b0}};
    if (empty_o) begin
      rdata_o = {W{1'b0}};
    end else begin
      rdata_o = mem_q[rd_ptr_q];
    end
  end

endmodule

// File: rtl/pixel_stream_packer.sv
// Packs a one-pixel-per-cycle RGB888 stream into little-endian 32-bit words,
// zero-pads each row to a 4-byte boundary, and buffers the words in a FWFT
// FIFO behind a valid/ready port. The source cannot stall, so a full FIFO
// drops the word and raises a sticky overflow flag instead of back-pressuring.
module pixel_stream_packer
  import pixel_stream_packer_pkg::*;
#(
  parameter int WIDTH      = 768,
  parameter int HEIGHT     = 512,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSYNC,
  input  logic [7:0]  DATA_R0,
  input  logic [7:0]  DATA_G0,
  input  logic [7:0]  DATA_B0,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        frame_done,
  output logic        overflow
);

  localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  state_e            state_q, state_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [23:0]       acc_q, acc_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic              pad_pend_q, pad_pend_d;
  logic [31:0]       pad_word_q, pad_word_d;
  logic              frame_done_q, frame_done_d;
  logic              overflow_q, overflow_d;

  logic              sample_s;
  logic              row_end_s;
  logic              frame_end_s;
  logic [47:0]       shifted_s;
  logic              data_push_s;
  logic [31:0]       data_word_s;
  logic              data_last_s;
  logic              push_s;
  logic [FIFO_W-1:0] push_data_s;
  logic              pop_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [FIFO_W-1:0] fifo_rdata_s;

  // Pixel sampling, byte accumulation, word completion and row-end padding
  always_comb begin
    sample_s    = HSYNC && (state_q != ST_DRAIN);
    row_end_s   = sample_s && (col_q == CW'(WIDTH - 1));
    frame_end_s = row_end_s && (row_q == RW'(HEIGHT - 1));
    // New pixel bytes land directly above the pending lane bytes
    shifted_s   = ({24'h000000, DATA_B0, DATA_G0, DATA_R0} << {lane_q, 3'b000})
                | {24'h000000, acc_q};
    lane_d      = lane_q;
    acc_d       = acc_q;
    col_d       = col_q;
    row_d       = row_q;
    data_push_s = 1'b0;
    data_word_s = shifted_s[31:0];
    data_last_s = 1'b0;
    pad_pend_d  = 1'b0;
    pad_word_d  = pad_word_q;
    if (sample_s) begin
      if (lane_q == 2'd0) begin
        lane_d = 2'd3;
        acc_d  = shifted_s[23:0];
      end else begin
        data_push_s = 1'b1;
        lane_d      = lane_q - 2'd1;
        acc_d       = {8'h00, shifted_s[47:32]};
      end
      if (row_end_s) begin
        lane_d = 2'd0;
        acc_d  = 24'h000000;
        col_d  = {CW{1'b0}};
        if (lane_q == 2'd1) begin
          // Row ends exactly on a word boundary: the data word closes the row
          data_last_s = 1'b1;
        end else if (lane_q == 2'd0) begin
          pad_pend_d = 1'b1;
          pad_word_d = shifted_s[31:0];
        end else begin
          pad_pend_d = 1'b1;
          pad_word_d = {16'h0000, shifted_s[47:32]};
        end
        if (frame_end_s) begin
          row_d = {RW{1'b0}};
        end else begin
          row_d = row_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end else begin
      lane_d = lane_q;
      acc_d  = acc_q;
    end
  end

  // FIFO write source and overflow detection; a pending pad word never
  // coincides with a data word because a row's first pixel completes none
  always_comb begin
    push_s      = pad_pend_q || data_push_s;
    push_data_s = {data_last_s, data_word_s};
    if (pad_pend_q) begin
      push_data_s = {1'b1, pad_word_q};
    end else begin
      push_data_s = {data_last_s, data_word_s};
    end
    pop_s      = out_ready && !fifo_empty_s;
    overflow_d = overflow_q;
    if (push_s && fifo_full_s && !pop_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Frame sequencing: run rows, drain the pipeline, then report completion
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (HSYNC) begin
          state_d = frame_end_s ? ST_DRAIN : ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (frame_end_s) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (!pad_pend_q && fifo_empty_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        if (HSYNC) begin
          state_d = frame_end_s ? ST_DRAIN : ST_RUN;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    frame_done_d = (state_d == ST_DONE);
  end

  // State, packing and status registers
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q      <= ST_IDLE;
      lane_q       <= {LANE_W{1'b0}};
      acc_q        <= 24'h000000;
      col_q        <= {CW{1'b0}};
      row_q        <= {RW{1'b0}};
      pad_pend_q   <= 1'b0;
      pad_word_q   <= 32'h00000000;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      acc_q        <= acc_d;
      col_q        <= col_d;
      row_q        <= row_d;
      pad_pend_q   <= pad_pend_d;
      pad_word_q   <= pad_word_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
    end
  end

  sync_fifo_fwft #(
    .DEPTH (FIFO_DEPTH),
    .W     (FIFO_W)
  ) u_fifo (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .push_i  (push_s),
    .wdata_i (push_data_s),
    .pop_i   (pop_s),
    .rdata_o (fifo_rdata_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  assign out_data   = fifo_rdata_s[31:0];
  assign out_last   = fifo_rdata_s[32];
  assign out_valid  = !fifo_empty_s;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;

endmodule

// File: doc/pixel_stream_packer.md
Name: pixel_stream_packer

Overview:
- Downstream stage of the pixel reader. Consumes its one-pixel-per-cycle RGB888 stream, qualified by HSYNC.
- Packs bytes little-endian into 32-bit words and inserts zero padding at the end of each row, giving BMP 4-byte row alignment.
- Buffers words in a small FIFO and presents them on a valid/ready interface to the frame writer or memory writer.
- The source cannot stall, so a FIFO overrun is flagged, never back-pressured.

Parameters:
- WIDTH, 768, pixels per row.
- HEIGHT, 512, rows per frame.
- FIFO_DEPTH, 16, word FIFO entries; must be a power of 2 and at least 4.

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  reset
- HSYNC  in  1  pixel valid; one pixel is sampled per cycle while high
- DATA_R0  in  8  red byte
- DATA_G0  in  8  green byte
- DATA_B0  in  8  blue byte
- out_data  out  32  packed word; first byte in [7:0]
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts word
- out_last  out  1  high with the final word of each row
- frame_done  out  1  frame fully delivered
- overflow  out  1  sticky; a word was dropped because the FIFO was full

Behaviour:
- Reset is HRESETn, asynchronous, active-low; the clock is HCLK.
- Reset values: all outputs 0. FIFO is empty, accumulator lane count is 0, col/row counters are 0, state is IDLE.
- Byte order per pixel: R, G, B, in arrival order. Rows are emitted in arrival order; this block does no row reversal.
- Accumulator: holds 0..3 pending bytes (lane). Each sampled pixel adds 3 bytes.
- Word completion on a sampled pixel, by lane before the pixel:
  - lane 0: no word; lane becomes 3.
  - lane 1: push 1 word; lane becomes 0.
  - lane 2: push 1 word; lane becomes 1.
  - lane 3: push 1 word; lane becomes 2.
- At most one push per cycle from pixel data.
- Row end (col == WIDTH-1 sampled): if the residual lane is nonzero, the residual bytes plus zero fill form a pad word.
  - The pad word is held in a pending register and pushed on the next cycle.
  - That push cannot collide with a data push, because the first pixel of a row never completes a word.
  - lane is cleared at row end.
- out_last is tagged on the last word of the row: the pad word if one exists, otherwise the data word completed by the last pixel.
- Words per row = ceil(3*WIDTH/4); for the defaults this is 576 per row, 294912 per frame.
- FIFO: first-word-fall-through. out_valid rises the cycle after the push edge.
  - A pop occurs when out_valid && out_ready.
  - Simultaneous push and pop when full is allowed; the pop frees the slot.
- Overflow: a push while full and not popping is dropped and sets overflow=1. It clears only on reset. Packing continues normally.
- HSYNC low mid-row: accumulator and counters hold; output is identical to a gap-free stream.
- State machine:
  - IDLE -> RUN on HSYNC.
  - RUN -> DRAIN after the last pixel of row HEIGHT-1 is sampled.
  - DRAIN -> DONE when no pad word is pending and the FIFO is empty.
  - DONE holds frame_done=1 until HSYNC is seen; then frame_done=0, counters and lane restart at 0, and the state goes to RUN with that pixel sampled.
- Pixels with HSYNC high in DRAIN are ignored. They do not alter overflow or data.
- Reset mid-frame: everything returns to reset values immediately; partial words are discarded.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, RUN, DRAIN, DONE);
  - BYTES_PER_ROW = 3*WIDTH;
  - WORDS_PER_ROW = (3*WIDTH+3)/4;
  - lane width (2 bits).
- One sub-module, sync_fifo_fwft:
  - 33 bits wide, carrying data and last;
  - parameter DEPTH;
  - signals full, empty, push, pop.
- Packing, counters and FSM stay in the top module.

Test Plan:
- WIDTH=4 HEIGHT=1, out_ready=1, pixels (01,02,03) (04,05,06) (07,08,09) (0A,0B,0C) -> words 04030201, 08070605, 0C0B0A09; out_last on the third; frame_done=1 after drain; overflow=0.
- WIDTH=5 HEIGHT=2, byte values 01..0F per row, continuous HSYNC -> 4 words per row; the 4th is 000F0E0D with out_last=1; row 2 is identical; 8 words total.
- WIDTH=8 HEIGHT=1, FIFO_DEPTH=16, out_ready=0 for 10 cycles then 1 -> all 6 words delivered in order; overflow stays 0.
- WIDTH=64 HEIGHT=1, FIFO_DEPTH=16, out_ready=0 throughout -> 16 words retained, overflow=1 at the 17th push; after out_ready=1, exactly 16 words drain, then frame_done=1.
- WIDTH=8 HEIGHT=1 with HSYNC low for 3 cycles after pixel 2 -> output words identical to the gap-free run.
- HRESETn pulsed low after 10 pixels -> all outputs 0 at once; a new frame after reset packs from col 0 with correct words.
